// File: rtl/pe_conv1d_seq.sv
// pe_conv1d_seq
//   Sequential multi-channel 1-D convolution processing element. A start
//   handshake in IDLE latches one feature-map window, one kernel and the
//   channel count. The OSIZE = FSIZE-KSIZE+1 output sums are then built with
//   a single time-shared multiply-accumulate, one product per cycle. A
//   one-cycle done pulse marks completion.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      job request, sampled only in IDLE
//   nc         channel count for this job (valid range 1..NC_MAX)
//   featureMap FSIZE*NC_MAX elements of DW bits, element index = pos*nc + ch
//   kernelMap  KSIZE*NC_MAX elements of DW bits, element index = tap*nc + ch
//   busy       job in progress (RUN or DONE)
//   done       one-cycle completion pulse
//   err        last accepted job had an out-of-range nc
//   ovf        last job overflowed ACC_W in at least one sum
//   ofm        OSIZE sums of ACC_W bits, sum j at [ACC_W*j +: ACC_W]
module pe_conv1d_seq #(
    parameter int FSIZE    = 5,
    parameter int KSIZE    = 3,
    parameter int NC_MAX   = 8,
    parameter int DW       = 8,
    parameter int ACC_W    = 25,
    parameter int SATURATE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [8:0]                            nc,
    input  logic [FSIZE*NC_MAX*DW-1:0]            featureMap,
    input  logic [KSIZE*NC_MAX*DW-1:0]            kernelMap,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    output logic                                  ovf,
    output logic [(FSIZE-KSIZE+1)*ACC_W-1:0]      ofm
);

    localparam int OSIZE = FSIZE - KSIZE + 1;
    localparam int FMW   = FSIZE * NC_MAX * DW;
    localparam int KMW   = KSIZE * NC_MAX * DW;
    localparam int KW    = (KSIZE * NC_MAX > 1) ? $clog2(KSIZE * NC_MAX) : 1;
    localparam int JW    = (OSIZE > 1) ? $clog2(OSIZE) : 1;
    localparam int PW    = 2 * DW;
    // One guard bit above the wider of accumulator and product.
    localparam int SW    = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic [SW-1:0] ACC_MAX = (SW'(1) << ACC_W) - SW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [FMW-1:0]         fmap_r;
    logic [KMW-1:0]         kern_r;
    logic [8:0]             nc_r;
    logic [KW-1:0]          k;
    logic [JW-1:0]          j;
    logic [ACC_W-1:0]       acc;
    logic [OSIZE*ACC_W-1:0] sums;

    logic [31:0]            fidx;
    logic [31:0]            k_last;
    logic [DW-1:0]          f_el;
    logic [DW-1:0]          k_el;
    logic [PW-1:0]          prod;
    logic [SW-1:0]          sum;
    logic                   sum_ovf;
    logic [ACC_W-1:0]       acc_next;
    logic                   k_wrap;
    logic                   j_last;
    logic                   nc_ok;

    // Operand fetch uses shifts of the latched vectors, so the element
    // offsets (k + nc*j, k) can be computed at full width.
    always_comb begin
        fidx     = 32'(k) + 32'(nc_r) * 32'(j);
        k_last   = 32'(KSIZE) * 32'(nc_r) - 32'd1;
        f_el     = DW'(fmap_r >> (fidx * 32'(DW)));
        k_el     = DW'(kern_r >> (32'(k) * 32'(DW)));
        prod     = PW'(f_el) * PW'(k_el);
        sum      = SW'(acc) + SW'(prod);
        sum_ovf  = (sum > ACC_MAX);
        acc_next = sum[ACC_W-1:0];
        if (sum_ovf && (SATURATE != 0)) begin
            acc_next = '1;
        end
        k_wrap   = (32'(k) == k_last);
        j_last   = (j == JW'(OSIZE - 1));
        nc_ok    = (nc != '0) && (nc <= 9'(NC_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            ovf    <= 1'b0;
            ofm    <= '0;
            fmap_r <= '0;
            kern_r <= '0;
            nc_r   <= '0;
            k      <= '0;
            j      <= '0;
            acc    <= '0;
            sums   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        ovf  <= 1'b0;
                        if (nc_ok) begin
                            fmap_r <= featureMap;
                            kern_r <= kernelMap;
                            nc_r   <= nc;
                            acc    <= '0;
                            sums   <= '0;
                            k      <= '0;
                            j      <= '0;
                            err    <= 1'b0;
                            state  <= RUN;
                        end else begin
                            err   <= 1'b1;
                            ofm   <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (sum_ovf) begin
                        ovf <= 1'b1;
                    end
                    if (k_wrap) begin
                        // Sum j is complete: park it and restart the running
                        // accumulator for the next output position.
                        k   <= '0;
                        acc <= '0;
                        for (int unsigned i = 0; i < OSIZE; i++) begin
                            if (JW'(i) == j) begin
                                sums[ACC_W*i +: ACC_W] <= acc_next;
                            end
                        end
                        if (j_last) begin
                            // The final sum is still in flight here, so it is
                            // merged into ofm directly from acc_next.
                            for (int unsigned i = 0; i < OSIZE; i++) begin
                                ofm[ACC_W*i +: ACC_W] <= (JW'(i) == j) ? acc_next
                                                                       : sums[ACC_W*i +: ACC_W];
                            end
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            j <= j + JW'(1);
                        end
                    end else begin
                        acc <= acc_next;
                        k   <= k + KW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pe_conv1d_seq.md
# pe_conv1d_seq

Sequential, parametrised successor to the combinational multi-channel 1-D convolution PE. It latches one feature-map window and one kernel on a start handshake. It then computes all FSIZE-KSIZE+1 output sums with a single time-shared multiply-accumulate, one MAC per cycle. It signals completion with a one-cycle done pulse, adds configurable overflow handling and input-error detection, and sits between the feature/kernel buffers and the output-map writer.

## Interface
- FSIZE, 5, feature positions per window
- KSIZE, 3, kernel taps
- NC_MAX, 8, maximum channel count
- DW, 8, unsigned element width
- ACC_W, 25, accumulator/output width per sum
- SATURATE, 0, 0 = wrap modulo 2^ACC_W, 1 = clamp to 2^ACC_W-1
- OSIZE (localparam) = FSIZE-KSIZE+1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- nc  in  9  channel count for this job
- featureMap  in  FSIZE*NC_MAX*DW  element e at bits [DW*e+DW-1 : DW*e]; element index = pos*nc + ch
- kernelMap  in  KSIZE*NC_MAX*DW  element index = tap*nc + ch
- busy  out  1  job in progress (RUN or DONE)
- done  out  1  one-cycle completion pulse
- err  out  1  last accepted job had nc==0 or nc>NC_MAX
- ovf  out  1  last job overflowed ACC_W in at least one sum
- ofm  out  OSIZE*ACC_W  sum j at bits [ACC_W*j+ACC_W-1 : ACC_W*j]

## Operation
- FSM states:
  - IDLE: start=1 with 1<=nc<=NC_MAX latches featureMap, kernelMap and nc into internal registers. It also clears the accumulators, k, j and ovf, clears err, and goes to RUN.
  - IDLE with start=1 and an invalid nc: sets err=1, loads ofm with zeros and goes straight to DONE.
  - RUN: each cycle, acc[j] += kernel[k] * fmap[k + nc*j], with unsigned DW×DW products.
  - RUN counter update: if k == KSIZE*nc-1 then k=0, and j either increments or, when j == OSIZE-1, the FSM goes to DONE; otherwise k increments.
  - DONE: done=1 for exactly one cycle, then IDLE.
- ofm is loaded with the final sums, including the last product, at the RUN→DONE edge. It holds that value until the next completion or until reset.
- Overflow handling per accumulate:
  - A sum exceeding 2^ACC_W-1 sets ovf, which stays set for the rest of the job.
  - SATURATE=1: the accumulator is clamped and stays clamped.
  - SATURATE=0: the accumulator wraps.
- The latched copies decouple the job from the inputs. featureMap, kernelMap and nc may change freely after the start cycle.
- start while busy is ignored and has no queueing. start in the DONE cycle is also ignored.
- Index bounds: max fmap index = nc*FSIZE-1 and max kernel index = KSIZE*nc-1, both within the port widths for nc<=NC_MAX.

## Timing
- Reset (rst_n low, any state, including mid-RUN): state=IDLE; busy, done, err and ovf = 0; ofm = 0; accumulators and counters = 0. The partial job is discarded.
- Start accepted at edge E0. MAC cycles occupy E1..EN, with N = OSIZE*KSIZE*nc. The RUN→DONE transition happens on edge EN.
- done is high for the cycle after EN (between edges EN and EN+1), with ofm, ovf and err valid in that cycle.
- busy is high from E0 to EN+1, and a new start is accepted at edge EN+2 at the earliest.
- Invalid nc: DONE is entered at E0, done is high for the following cycle, ofm=0 and err=1.
- Defaults: N = 3*3*nc, so 9..72 MAC cycles. The worst-case sum is 24*255*255 = 1,560,600 < 2^25, so no overflow is possible at the default parameters.

## Test plan
- Single channel: nc=1, fmap=[1,2,3,4,5], kernel=[1,1,1], start pulse. Required: ofm=[6,9,12], done exactly 10 cycles after the start edge, err=0, ovf=0.
- Two channels: nc=2, ch0 value pos+1, ch1 value 10, all kernel elements 1. Required: ofm=[36,39,42], done 19 cycles after start.
- Invalid nc: start with nc=0, then with nc=9. Required: done the next cycle, err=1, ofm=0, busy high for 1 cycle only.
- Overflow: ACC_W=16, nc=1, all elements 255, so each true sum is 195075. Required with SATURATE=1: ofm=[65535,65535,65535], ovf=1. Required with SATURATE=0: each sum = 64003, ovf=1.
- Reset mid-run: assert rst_n low at the 4th MAC cycle of the single-channel job. Required: busy=0, done=0 and ofm=0 immediately. A following start then completes with [6,9,12].
- Busy protection: change the inputs and pulse start during RUN. Required: the original result is delivered and no second done pulse occurs.
